karatsuba_mul_arbiter: RTL and testbench
========================================

// Module: karatsuba_mul_arbiter
// PURPOSE
// Shares one pipelined karatsuba_mul_rec instance among NUM_REQ requesters. Round-robin grant,
// at most one operand pair issued per cycle. Each in-flight op is tagged in an ordered tag FIFO.
// Returned products go out with the owning requester id. Sits between the client engines and the multiplier.
// PARAMETERS
// WIDTH       16  operand width; must equal the multiplier's WIDTH
// NUM_REQ     4   number of requesters, 2..16
// ID_W        2   requester id width, $clog2(NUM_REQ)
// FIFO_DEPTH  8   tag FIFO depth = max in-flight ops; power of 2, >= multiplier latency (7 at WIDTH=16)
// PORTS
// clk                input   1              rising-edge clock
// reset              input   1              asynchronous, active-low reset
// req_valid          input   NUM_REQ        requester i has an operand pair
// req_a              input   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
// req_b              input   NUM_REQ*WIDTH  operand B, same packing
// req_ready          output  NUM_REQ        one-hot or zero; pair i accepted when req_valid[i]&req_ready[i]
// mul_a, mul_b       output  WIDTH          registered operands to the multiplier
// mul_operands_valid output  1              registered issue strobe to the multiplier
// mul_product        input   2*WIDTH        multiplier product
// mul_product_valid  input   1              multiplier result strobe
// rsp_valid          output  1              result strobe; no backpressure, clients always accept
// rsp_id             output  ID_W           requester that owns rsp_product
// rsp_product        output  2*WIDTH        product, passed through bit-exact
// inflight           output  $clog2(FIFO_DEPTH)+1  ops issued and not yet returned
// err_orphan         output  1              sticky: product arrived with tag FIFO empty
// BEHAVIOUR
// - Reset (reset=0, asynchronous): all outputs 0; RR pointer=NUM_REQ-1; FIFO empty; inflight=0.
// - Tie the multiplier's reset to the same net. Hold reset low >=1 clk edge so its synchronous pipeline flushes.
// - Credit: can_issue = (inflight < FIFO_DEPTH). If !can_issue, req_ready=0 for all requesters.
// - Grant, combinational: scan from ptr+1 with wrap; the first i with req_valid[i] gets req_ready[i]=can_issue.
// - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
// - On accept of i at edge T:
//   - mul_a/mul_b<=req_a/b[i] and mul_operands_valid<=1 (visible cycle T+1, 1-cycle issue latency).
//   - Push i into the tag FIFO; ptr<=i.
// - With no accept: mul_operands_valid<=0. mul_a/mul_b hold their values.
// - A requester holds req_valid and its operands stable until accepted.
// - Return at edge where mul_product_valid=1:
//   - Pop the FIFO head.
//   - rsp_valid<=1, rsp_id<=head, rsp_product<=mul_product (1-cycle return latency).
// - Ordering: the multiplier is in-order and fixed latency, so the FIFO head always matches the product.
// - Orphan: mul_product_valid with FIFO empty -> no pop, rsp_valid<=0, err_orphan<=1. Only reset clears it.
// - inflight: +1 on accept, -1 on pop; both in the same cycle -> unchanged. Never exceeds FIFO_DEPTH.
// - FIFO full with pop in the same cycle: can_issue uses the registered inflight, so no accept that cycle.
// - End-to-end latency, accept edge to rsp_valid: 1 + L_mul + 1 cycles (9 at WIDTH=16).
// - Sustained throughput is 1 op/cycle when FIFO_DEPTH >= L_mul + 2.
// - Reset mid-operation: in-flight ops are dropped. No rsp is produced for them after reset is released.
// TESTING
// - Single op: req 2 sends A=16'd300, B=16'd7 -> one rsp 9 cycles later, rsp_id=2, rsp_product=2100.
// - Fairness: all 4 req_valid held high for 8 accepts -> grant order 0,1,2,3,0,1,2,3.
//   - Each requester's rsp_id sequence matches its own issue order.
// - Back-to-back: req 1 streams 20 pairs (A=i, B=i+3) -> rsp_valid high 20 consecutive cycles.
//   - Products are i*(i+3), in order.
// - Credit limit: FIFO_DEPTH=4 with a latency-7 multiplier model, req 0 valid continuously.
//   - After 4 accepts req_ready stays 0 until the first pop. inflight peaks at 4, never 5.
// - Orphan: force mul_product_valid=1 with FIFO empty -> err_orphan=1, rsp_valid=0.
//   - err_orphan stays high until reset.
// - Reset mid-flight: assert reset with 3 ops in flight, hold 2 edges, release.
//   - inflight=0 and no rsp_valid for the dropped ops.
//   - A new op then completes correctly.

Source files
------------

// File: rtl/karatsuba_mul_arbiter.sv
// karatsuba_mul_arbiter: round-robin front end sharing one pipelined multiplier among
// NUM_REQ clients; an in-order tag FIFO routes each returned product to its owner.
module karatsuba_mul_arbiter #(
    parameter int WIDTH      = 16,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*WIDTH-1:0]    req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [WIDTH-1:0]            mul_a,
    output logic [WIDTH-1:0]            mul_b,
    output logic                        mul_operands_valid,
    input  logic [2*WIDTH-1:0]          mul_product,
    input  logic                        mul_product_valid,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [2*WIDTH-1:0]          rsp_product,
    output logic [$clog2(FIFO_DEPTH):0] inflight,
    output logic                        err_orphan
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  tag_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic             can_issue;
    logic             fifo_empty;
    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Credit comes from the registered count, so a pop never frees a slot in its own cycle.
    assign can_issue  = (inflight < CW'(FIFO_DEPTH));
    assign fifo_empty = (inflight == '0);
    assign accept     = grant_found && can_issue;
    assign pop        = mul_product_valid && !fifo_empty;

    assign sel_a = req_a[int'(grant_id)*WIDTH +: WIDTH];
    assign sel_b = req_b[int'(grant_id)*WIDTH +: WIDTH];

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        req_ready   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr                <= ID_W'(NUM_REQ - 1);
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            inflight           <= '0;
            mul_a              <= '0;
            mul_b              <= '0;
            mul_operands_valid <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_id             <= '0;
            rsp_product        <= '0;
            err_orphan         <= 1'b0;
        end else begin
            // issue stage
            mul_operands_valid <= accept;
            if (accept) begin
                mul_a  <= sel_a;
                mul_b  <= sel_b;
                ptr    <= grant_id;
                wr_ptr <= wr_ptr + 1'b1;
            end
            // return stage
            rsp_valid <= pop;
            if (pop) begin
                rsp_id      <= tag_mem[rd_ptr];
                rsp_product <= mul_product;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (mul_product_valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Bench for karatsuba_mul_arbiter: behavioural 7-stage multiplier plus an ordered scoreboard
// of expected (owner, a*b) pairs; a second instance with FIFO_DEPTH=4 exercises credit stalls.
module tb_karatsuba_mul_arbiter;
    localparam int W    = 16;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int D    = 16;
    localparam int D4   = 4;
    localparam int LMUL = 7;
    // accept edge to first edge after which rsp_valid is seen (accept cycle counts as cycle 1 -> cycle 9)
    localparam int LAT_EDGES = 8;

    typedef struct {
        int          id;
        logic [31:0] prod;
        int          acyc;
    } ent_t;

    logic clk;
    logic reset;
    logic force_pv;

    logic [N-1:0]        req_valid, req_ready;
    logic [N*W-1:0]      req_a, req_b;
    logic [W-1:0]        mul_a, mul_b;
    logic                mul_operands_valid;
    logic [2*W-1:0]      mul_product;
    logic                mul_product_valid;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [2*W-1:0]      rsp_product;
    logic [$clog2(D):0]  inflight;
    logic                err_orphan;

    logic [N-1:0]        req_valid4, req_ready4;
    logic [N*W-1:0]      req_a4, req_b4;
    logic [W-1:0]        mul_a4, mul_b4;
    logic                mul_operands_valid4;
    logic [2*W-1:0]      mul_product4;
    logic                mul_product_valid4;
    logic                rsp_valid4;
    logic [IDW-1:0]      rsp_id4;
    logic [2*W-1:0]      rsp_product4;
    logic [$clog2(D4):0] inflight4;
    logic                err_orphan4;

    karatsuba_mul_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
        .mul_operands_valid(mul_operands_valid), .mul_product(mul_product),
        .mul_product_valid(mul_product_valid), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .inflight(inflight), .err_orphan(err_orphan));

    karatsuba_mul_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .FIFO_DEPTH(D4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid4), .req_a(req_a4), .req_b(req_b4),
        .req_ready(req_ready4), .mul_a(mul_a4), .mul_b(mul_b4),
        .mul_operands_valid(mul_operands_valid4), .mul_product(mul_product4),
        .mul_product_valid(mul_product_valid4), .rsp_valid(rsp_valid4), .rsp_id(rsp_id4),
        .rsp_product(rsp_product4), .inflight(inflight4), .err_orphan(err_orphan4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency in-order multipliers sharing the arbiter reset (synchronous flush).
    logic [LMUL-1:0] pv_pipe, pv4_pipe;
    logic [2*W-1:0]  pp_pipe [LMUL];
    logic [2*W-1:0]  pp4_pipe [LMUL];

    always @(posedge clk) begin
        if (!reset) begin
            pv_pipe  <= '0;
            pv4_pipe <= '0;
        end else begin
            pv_pipe  <= {pv_pipe[LMUL-2:0], mul_operands_valid};
            pv4_pipe <= {pv4_pipe[LMUL-2:0], mul_operands_valid4};
        end
        pp_pipe[0]  <= 32'(mul_a) * 32'(mul_b);
        pp4_pipe[0] <= 32'(mul_a4) * 32'(mul_b4);
        for (int k = 1; k < LMUL; k++) begin
            pp_pipe[k]  <= pp_pipe[k-1];
            pp4_pipe[k] <= pp4_pipe[k-1];
        end
    end

    assign mul_product_valid  = pv_pipe[LMUL-1] | force_pv;
    assign mul_product        = pp_pipe[LMUL-1];
    assign mul_product_valid4 = pv4_pipe[LMUL-1];
    assign mul_product4       = pp4_pipe[LMUL-1];

    int checks = 0;
    int errors = 0;

    ent_t        q[$];
    ent_t        q4[$];
    int          ptr_m, ptr4_m;
    bit          orphan_m, orphan4_m;
    logic [W-1:0] ma_m, mb_m, ma4_m, mb4_m;
    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    logic [W-1:0] ra4, rb4;
    int          cyc = 0;
    int          last_acc, last_acc4;
    int          rsp_count = 0;
    int          cur_run = 0;
    int          max_run = 0;
    int          last_id = 0;
    logic [31:0] last_prod = '0;
    int          pk4 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Round robin: first valid requester after the last granted one, if a credit is free.
    function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v, input int p, input bit credit);
        logic [N-1:0] g;
        bit found;
        g = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (p + k) % N;
            if (!found && v[i]) begin
                found = 1'b1;
                if (credit) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic step();
        logic [N-1:0] eg, eg4;
        bit erv, erv4;
        ent_t e, e4;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = ra[i];
            req_b[i*W +: W] = rb[i];
        end
        req_a4 = {{((N-1)*W){1'b0}}, ra4};
        req_b4 = {{((N-1)*W){1'b0}}, rb4};
        @(negedge clk);
        eg  = exp_grant(req_valid, ptr_m, q.size() < D);
        eg4 = exp_grant(req_valid4, ptr4_m, q4.size() < D4);
        chk("req_ready", req_ready, eg);
        chk("req_ready4", req_ready4, eg4);
        erv  = mul_product_valid && (q.size() > 0);
        erv4 = mul_product_valid4 && (q4.size() > 0);
        if (mul_product_valid && q.size() == 0) orphan_m = 1'b1;
        if (mul_product_valid4 && q4.size() == 0) orphan4_m = 1'b1;
        if (erv) e = q.pop_front();
        if (erv4) e4 = q4.pop_front();
        last_acc  = -1;
        last_acc4 = -1;
        for (int i = 0; i < N; i++) begin
            if (eg[i]) last_acc = i;
            if (eg4[i]) last_acc4 = i;
        end
        if (last_acc >= 0) begin
            q.push_back('{last_acc, 32'(ra[last_acc]) * 32'(rb[last_acc]), cyc + 1});
            ptr_m = last_acc;
            ma_m  = ra[last_acc];
            mb_m  = rb[last_acc];
        end
        if (last_acc4 >= 0) begin
            q4.push_back('{last_acc4, 32'(ra4) * 32'(rb4), cyc + 1});
            ptr4_m = last_acc4;
            ma4_m  = ra4;
            mb4_m  = rb4;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("mul_operands_valid", mul_operands_valid, last_acc >= 0);
        chk("mul_a", mul_a, ma_m);
        chk("mul_b", mul_b, mb_m);
        chk("rsp_valid", rsp_valid, erv);
        if (erv) begin
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_product", rsp_product, e.prod);
            chk("latency", cyc - e.acyc, LAT_EDGES);
        end
        chk("inflight", inflight, q.size());
        chk("err_orphan", err_orphan, orphan_m);
        chk("mul_operands_valid4", mul_operands_valid4, last_acc4 >= 0);
        chk("mul_a4", mul_a4, ma4_m);
        chk("rsp_valid4", rsp_valid4, erv4);
        if (erv4) begin
            chk("rsp_id4", rsp_id4, e4.id);
            chk("rsp_product4", rsp_product4, e4.prod);
            chk("latency4", cyc - e4.acyc, LAT_EDGES);
        end
        chk("inflight4", inflight4, q4.size());
        chk("err_orphan4", err_orphan4, orphan4_m);
        if (rsp_valid) begin
            rsp_count++;
            cur_run++;
            last_id   = int'(rsp_id);
            last_prod = rsp_product;
        end else begin
            cur_run = 0;
        end
        if (cur_run > max_run) max_run = cur_run;
        if (int'(inflight4) > pk4) pk4 = int'(inflight4);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_mul_valid", mul_operands_valid, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_err_orphan", err_orphan, 0);
        chk("rst_inflight4", inflight4, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        q4.delete();
        ptr_m     = N - 1;
        ptr4_m    = N - 1;
        orphan_m  = 1'b0;
        orphan4_m = 1'b0;
        ma_m  = '0;
        mb_m  = '0;
        ma4_m = '0;
        mb4_m = '0;
    endtask

    initial begin
        int order [8];
        int exp_order [8];
        int base;
        int n;
        reset = 1'b0;
        force_pv = 1'b0;
        req_valid = '0;
        req_valid4 = '0;
        req_a = '0;
        req_b = '0;
        req_a4 = '0;
        req_b4 = '0;
        ra4 = '0;
        rb4 = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        do_reset();

        // single op from requester 2
        base = rsp_count;
        ra[2] = 16'd300;
        rb[2] = 16'd7;
        req_valid = 4'b0100;
        step();
        chk("single_grant", last_acc, 2);
        req_valid = '0;
        repeat (12) step();
        chk("single_rsp_count", rsp_count - base, 1);
        chk("single_rsp_id", last_id, 2);
        chk("single_rsp_product", last_prod, 2100);

        // fairness with all four requesting
        do_reset();
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < N; i++) begin
            ra[i] = W'($urandom);
            rb[i] = W'($urandom);
        end
        req_valid = 4'hF;
        n = 0;
        for (int s = 0; s < 16 && n < 8; s++) begin
            step();
            if (last_acc >= 0) begin
                order[n] = last_acc;
                n++;
                ra[last_acc] = W'($urandom);
                rb[last_acc] = W'($urandom);
            end
        end
        req_valid = '0;
        chk("fair_accepts", n, 8);
        for (int j = 0; j < 8; j++) chk($sformatf("fair_grant%0d", j), order[j], exp_order[j]);
        repeat (12) step();

        // back-to-back stream from requester 1
        n = 0;
        cur_run = 0;
        max_run = 0;
        ra[1] = 16'd0;
        rb[1] = 16'd3;
        req_valid = 4'b0010;
        for (int s = 0; s < 40 && n < 20; s++) begin
            step();
            if (last_acc == 1) begin
                n++;
                ra[1] = W'(n);
                rb[1] = W'(n + 3);
            end
        end
        req_valid = '0;
        repeat (12) step();
        chk("b2b_accepts", n, 20);
        chk("b2b_rsp_run", max_run, 20);
        chk("b2b_last_product", last_prod, 19 * 22);

        // random traffic, operands held until accepted
        for (int s = 0; s < 300; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    ra[i] = W'($urandom);
                    rb[i] = W'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            step();
            if (last_acc >= 0) req_valid[last_acc] = 1'b0;
        end
        req_valid = '0;
        repeat (12) step();
        chk("rand_drained", inflight, 0);

        // credit limit on the depth-4 instance
        n = 0;
        pk4 = 0;
        ra4 = W'($urandom);
        rb4 = W'($urandom);
        req_valid4 = 4'b0001;
        for (int s = 0; s < 30; s++) begin
            step();
            if (last_acc4 == 0) begin
                n++;
                ra4 = W'($urandom);
                rb4 = W'($urandom);
            end
            if (s == 8) chk("credit_stall_accepts", n, 4);
        end
        req_valid4 = '0;
        repeat (12) step();
        chk("credit_peak", pk4, 4);
        chk("credit_drained", inflight4, 0);

        // orphan product with nothing in flight
        force_pv = 1'b1;
        step();
        force_pv = 1'b0;
        chk("orphan_flag", err_orphan, 1);
        chk("orphan_no_rsp", rsp_valid, 0);
        repeat (5) step();
        chk("orphan_sticky", err_orphan, 1);

        // reset with three ops in flight
        ra[3] = W'($urandom);
        rb[3] = W'($urandom);
        req_valid = 4'b1000;
        for (int s = 0; s < 3; s++) begin
            step();
            if (last_acc == 3) begin
                ra[3] = W'($urandom);
                rb[3] = W'($urandom);
            end
        end
        req_valid = '0;
        step();
        chk("midflight_inflight", inflight, 3);
        do_reset();
        base = rsp_count;
        repeat (12) step();
        chk("dropped_no_rsp", rsp_count - base, 0);
        ra[0] = 16'd12345;
        rb[0] = 16'd54321;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (12) step();
        chk("post_reset_rsp_count", rsp_count - base, 1);
        chk("post_reset_rsp_id", last_id, 0);
        chk("post_reset_rsp_product", last_prod, 32'd670592745);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
